// File: rtl/hazard_pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, branch/jump redirect, memory-wait freeze and watchdog.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_pipeline_controller #(
    parameter int NBits       = 32,
    parameter int RegAddrBits = 5,
    parameter int MemTimeout  = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [RegAddrBits-1:0] id_rs_i,
    input  logic [RegAddrBits-1:0] id_rt_i,
    input  logic                   id_uses_rt_i,
    input  logic                   ex_mem_read_i,
    input  logic [RegAddrBits-1:0] ex_rt_i,
    input  logic                   branch_taken_i,
    input  logic                   jump_i,
    input  logic                   mem_busy_i,
    output logic                   pc_write_o,
    output logic                   if_id_write_o,
    output logic                   if_id_flush_o,
    output logic                   id_ex_flush_o,
    output logic                   ex_mem_write_o,
    output logic                   mem_timeout_o,
    output logic [1:0]             state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]            stall_count_o,
    output logic [15:0]            flush_count_o
`endif
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd2;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MemTimeout);

    if (MemTimeout < 1 || MemTimeout > 255 || NBits < 1) begin : g_param_check
        $error("hazard_pipeline_controller: MemTimeout must be 1..255 and NBits >= 1");
    end

    logic [1:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       load_use;

    logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write;

    assign load_use = ex_mem_read_i && (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        state_d      = ST_RUN;
        wait_cnt_d   = '0;

        case (state_q)
            ST_RUN, ST_LOAD_STALL: begin
                if (mem_busy_i) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    state_d      = ST_MEM_WAIT;
                    wait_cnt_d   = 8'd1;
                end else if (branch_taken_i) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (jump_i) begin
                    if_id_flush = 1'b1;
                end else if (state_q == ST_RUN && load_use) begin
                    // The load has already advanced past EX once we sit in LOAD_STALL.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    state_d     = ST_LOAD_STALL;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy_i) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    state_d      = ST_MEM_WAIT;
                    wait_cnt_d   = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase

        // Reset must release the pipeline at once, even between clock edges.
        if (reset_i) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_write = 1'b1;
        end

        timeout_d = timeout_q | (wait_cnt_d >= TIMEOUT_LIMIT);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pc_write_o     = pc_write;
    assign if_id_write_o  = if_id_write;
    assign if_id_flush_o  = if_id_flush;
    assign id_ex_flush_o  = id_ex_flush;
    assign ex_mem_write_o = ex_mem_write;
    assign mem_timeout_o  = timeout_q;
    assign state_o        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    localparam int CntW = (NBits > 16) ? 16 : NBits;

    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CntW-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (if_id_flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count_o = 16'(stall_cnt_q);
    assign flush_count_o = 16'(flush_cnt_q);
`endif

endmodule

// File: tb/tb_hazard_pipeline_controller.sv
// Randomized self-checking bench for hazard_pipeline_controller against a cycle-level reference model.
module tb_hazard_pipeline_controller;

    localparam int MT  = 6;
    localparam int RAB = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [RAB-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic           id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic           branch_taken = 1'b0, jump = 1'b0, mem_busy = 1'b0;
    logic           pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_timeout;
    logic [1:0]     state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0]    stall_count, flush_count;
`endif

    hazard_pipeline_controller #(
        .NBits(32), .RegAddrBits(RAB), .MemTimeout(MT)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_mem_read_i(ex_mem_read), .ex_rt_i(ex_rt),
        .branch_taken_i(branch_taken), .jump_i(jump), .mem_busy_i(mem_busy),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .ex_mem_write_o(ex_mem_write), .mem_timeout_o(mem_timeout),
        .state_o(state)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count_o(stall_count), .flush_count_o(flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pipeline mode (0 run, 1 one-bubble stall, 2 waiting on memory).
    int m_mode = 0, m_wait = 0, m_stalls = 0, m_flushes = 0;
    bit m_to = 1'b0;
    bit e_pc, e_ifid, e_iff, e_idf, e_exm;
    int nx_mode, nx_wait;

    logic [RAB-1:0] reg_pool [4] = '{5'd0, 5'd1, 5'd8, 5'd31};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_eval();
        bit hazard;
        hazard = ex_mem_read && (ex_rt != 0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        e_pc = 1; e_ifid = 1; e_iff = 0; e_idf = 0; e_exm = 1;
        nx_mode = 0; nx_wait = 0;
        if (m_mode == 2) begin
            if (mem_busy) begin
                e_pc = 0; e_ifid = 0; e_exm = 0;
                nx_mode = 2;
                nx_wait = (m_wait < 255) ? m_wait + 1 : 255;
            end
        end else if (mem_busy) begin
            e_pc = 0; e_ifid = 0; e_exm = 0;
            nx_mode = 2; nx_wait = 1;
        end else if (branch_taken) begin
            e_iff = 1; e_idf = 1;
        end else if (jump) begin
            e_iff = 1;
        end else if (m_mode == 0 && hazard) begin
            e_pc = 0; e_ifid = 0; e_idf = 1;
            nx_mode = 1;
        end
    endfunction

    task automatic drive(input logic [RAB-1:0] rs, input logic [RAB-1:0] rt, input bit uses,
                         input bit mr, input logic [RAB-1:0] ert, input bit br, input bit j,
                         input bit busy);
        id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mr; ex_rt = ert;
        branch_taken = br; jump = j; mem_busy = busy;
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle(input bit rst_pulse);
        #1;
        if (rst_pulse) begin
            reset = 1'b1;
            #1;
            check("rst_state", 32'(state), 32'd0);
            check("rst_pc_write", 32'(pc_write), 32'd1);
            check("rst_ex_mem_write", 32'(ex_mem_write), 32'd1);
            check("rst_flushes", 32'({if_id_flush, id_ex_flush}), 32'd0);
            check("rst_timeout", 32'(mem_timeout), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
            check("rst_stall_count", 32'(stall_count), 32'd0);
`endif
            reset = 1'b0;
            m_mode = 0; m_wait = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
            #1;
        end
        model_eval();
        check("state", 32'(state), 32'(m_mode));
        check("pc_write", 32'(pc_write), 32'(e_pc));
        check("if_id_write", 32'(if_id_write), 32'(e_ifid));
        check("if_id_flush", 32'(if_id_flush), 32'(e_iff));
        check("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
        check("ex_mem_write", 32'(ex_mem_write), 32'(e_exm));
        check("mem_timeout", 32'(mem_timeout), 32'(m_to));
`ifdef HAZARD_PERF_CNT_EN
        check("stall_count", 32'(stall_count), 32'(m_stalls));
        check("flush_count", 32'(flush_count), 32'(m_flushes));
`endif
        @(posedge clk);
        m_mode = nx_mode;
        m_wait = nx_wait;
        if (m_wait >= MT) m_to = 1'b1;
        if (!e_pc && m_stalls < 65535) m_stalls++;
        if (e_iff && m_flushes < 65535) m_flushes++;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_pc_write", 32'(pc_write), 32'd1);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        reset = 1'b0;

        // Load-use on rs, then the bubble cycle, then back to run.
        drive(5'd8, 5'd1, 0, 1, 5'd8, 0, 0, 0); cycle(0);
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0); cycle(0);
        cycle(0);
        // Destination $zero never stalls.
        drive(5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0); cycle(0);
        // Load-use on rt only when rt is a source.
        drive(5'd1, 5'd8, 1, 1, 5'd8, 0, 0, 0); cycle(0);
        drive(5'd1, 5'd8, 0, 1, 5'd8, 0, 0, 0); cycle(0);
        // Branch and jump beat load-use.
        drive(5'd8, 5'd1, 0, 1, 5'd8, 1, 0, 0); cycle(0);
        drive(5'd8, 5'd1, 0, 1, 5'd8, 0, 1, 0); cycle(0);
        // Load-use, then busy or branch during the bubble.
        drive(5'd8, 5'd1, 0, 1, 5'd8, 0, 0, 0); cycle(0);
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1); cycle(0);
        drive(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0); cycle(0);
        drive(5'd8, 5'd1, 0, 1, 5'd8, 0, 0, 0); cycle(0);
        drive(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0); cycle(0);
        // Five-cycle memory wait, redirects ignored while frozen.
        for (int i = 0; i < 5; i++) begin
            drive(5'd0, 5'd0, 0, 0, 5'd0, i[0], 1, 1); cycle(0);
        end
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0); cycle(0);
        check("no_timeout_short_wait", 32'(mem_timeout), 32'd0);
        // Long wait trips the watchdog, which stays set after release.
        for (int i = 0; i < 10; i++) begin
            drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1); cycle(0);
        end
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0); cycle(0);
        cycle(0);
        check("timeout_sticky", 32'(mem_timeout), 32'd1);
        // Async reset mid-wait.
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1); cycle(0);
        end
        cycle(1);
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0); cycle(0);

        for (int n = 0; n < 3000; n++) begin
            bit busy;
            busy = ($urandom_range(0, 99) < (mem_busy ? 80 : 15));
            drive(reg_pool[$urandom_range(0, 3)], reg_pool[$urandom_range(0, 3)],
                  1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 60),
                  reg_pool[$urandom_range(0, 3)], ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 99) < 10), busy);
            cycle($urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
